uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART core transmitter between `NUM_REQ` byte-stream requesters.
- Accepts one byte at a time over a valid/ready handshake.
- Issues a one-cycle `tx_start` with held `tx_data` to the core.
- Tracks the core's `tx_active` until the frame completes.
- Sits between the APB register layer or DMA-style clients and `uart_top`, in the `pclk` domain.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 16: cycles allowed after `tx_start` for `tx_active` to rise, ≥ 2.

Ports:
- `pclk`  in  1  clock.
- `presetn`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  arbitration enable; when low, no new byte is accepted.
- `req_valid`  in  `NUM_REQ`  per-requester byte available.
- `req_data`  in  `NUM_REQ*8`  requester i's byte in bits `[8i+7:8i]`.
- `req_ready`  out  `NUM_REQ`  one-hot accept; transfer occurs when `req_valid[i] && req_ready[i]`.
- `tx_start`  out  1  one-cycle start pulse to the core.
- `tx_data`  out  8  byte to the core, held stable from `tx_start` until the next accept.
- `tx_active`  in  1  core busy flag.
- `grant_id`  out  `$clog2(NUM_REQ)`  requester owning the current or last frame.
- `busy`  out  1  high in any state other than IDLE.
- `err_timeout`  out  1  one-cycle pulse when `tx_active` fails to rise.
- `tx_count`  out  16  completed-frame counter, wraps.

## Operation
- FSM states and transitions:
  - IDLE → LAUNCH on handshake.
  - LAUNCH → WAIT_ACT unconditionally.
  - WAIT_ACT → WAIT_DONE when `tx_active`=1.
  - WAIT_ACT → IDLE on timeout.
  - WAIT_DONE → IDLE when `tx_active`=0.
- `req_ready` is combinational. It is nonzero only in IDLE with `enable`=1, equal to the one-hot of the round-robin winner among asserted `req_valid`.
- Round-robin search starts at `(last_grant+1) mod NUM_REQ`. `last_grant` updates on every accept, including accepts that later time out.
- Requesters hold `req_valid`/`req_data` until accepted. Dropping `req_valid` before acceptance is legal and removes the request.
- On accept: `req_data` slice is captured into `tx_data`, `grant_id` is updated, and the timeout counter is cleared.
- Timeout counter:
  - Counts in WAIT_ACT.
  - When it reaches `BUSY_TIMEOUT` with `tx_active` still 0: pulse `err_timeout`, return to IDLE, leave `tx_count` unchanged.
- `tx_count` increments on the WAIT_DONE → IDLE transition only; FFFF wraps to 0000.
- `enable` falling mid-frame: the current frame completes normally; only new accepts are blocked.
- `tx_active` already high in LAUNCH (from a previous frame) is not expected. If it occurs, WAIT_ACT still advances immediately on `tx_active`=1.

## Timing
- Reset values: `req_ready`=0, `tx_start`=0, `tx_data`=00, `grant_id`=0, `busy`=0, `err_timeout`=0, `tx_count`=0000. State is IDLE and `last_grant`=`NUM_REQ-1`, so requester 0 wins first.
- Accept in cycle T. At T+1 the state is LAUNCH, `tx_start`=1 (registered), and `tx_data` is valid.
- `busy` rises at T+1.
- Minimum gap between two accepts: frame duration + 2 cycles. The first IDLE cycle after WAIT_DONE can accept.
- Simultaneous valid on all requesters: grants rotate 0,1,2,3,0… with no repeats while others wait.
- Reset asserted mid-frame: all outputs return to reset values asynchronously and `tx_start` never glitches high. The core is reset by the same `presetn`.

## Structure
- Package `uart_ctrl_pkg` holds:
  - the state enum (IDLE, LAUNCH, WAIT_ACT, WAIT_DONE);
  - `UART_DATA_W`=8;
  - `TX_CNT_W`=16.
- Sub-module `uart_rr_arbiter`: combinational one-hot round-robin picker. Inputs are the request vector and `last_grant`; outputs are one-hot grant plus index.
- FSM, capture registers, timeout counter and `tx_count` live in the top module.

## Test plan
- Single request: `req_valid[2]`=1 with data A5 → `req_ready[2]` for 1 cycle, `tx_start` pulse next cycle, `tx_data`=A5, `grant_id`=2, `tx_count`=1 after `tx_active` falls.
- All four valid continuously with bytes 10/11/12/13 → core sees 10,11,12,13,10 in that order.
- Core model never raises `tx_active`, `BUSY_TIMEOUT`=16 → `err_timeout` pulse 16 cycles after WAIT_ACT entry, then IDLE, `tx_count` unchanged, next requester granted.
- `enable`=0 with requests pending → `req_ready`=0 indefinitely. `enable` dropped during WAIT_DONE → frame completes and `tx_count` increments.
- Preload `tx_count` via 65535 frames (or force) → next frame reads 0000.
- `presetn` low during WAIT_DONE → all outputs at reset values immediately. After release, requester 0 wins first.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and widths for the UART transmit-side control logic.
package uart_ctrl_pkg;

    localparam int UART_DATA_W = 8;
    localparam int TX_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_ACT,
        WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: the search starts just after last_grant and
// returns the first asserted request as a one-hot vector plus its index.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_valid
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] pos;

    // Walk from the farthest candidate to the nearest so the nearest hit wins last.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos         = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (int'(last_grant) + k >= NUM_REQ) begin
                pos = ID_W'(int'(last_grant) + k - NUM_REQ);
            end else begin
                pos = ID_W'(int'(last_grant) + k);
            end
            if (req[pos]) begin
                grant       = '0;
                grant[pos]  = 1'b1;
                grant_idx   = pos;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters: round-robin accept,
// one-cycle start pulse, then tracks tx_active until the frame completes.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic                           enable,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_active,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           err_timeout,
    output logic [TX_CNT_W-1:0]            tx_count
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

    tx_state_t              state_reg, state_next;
    logic [ID_W-1:0]        last_grant_reg;
    logic [ID_W-1:0]        grant_id_reg;
    logic [UART_DATA_W-1:0] tx_data_reg;
    logic                   tx_start_reg;
    logic                   err_timeout_reg;
    logic [TX_CNT_W-1:0]    tx_count_reg;
    logic [TO_W-1:0]        timeout_cnt_reg;

    logic [NUM_REQ-1:0]     arb_grant;
    logic [ID_W-1:0]        arb_idx;
    logic                   arb_valid;
    logic                   accept;
    logic                   timeout_hit;
    logic                   frame_done;
    logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_bytes[gi] = req_data[gi*UART_DATA_W +: UART_DATA_W];
    end

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req         (req_valid),
        .last_grant  (last_grant_reg),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // presetn gates req_ready so the handshake is dead while reset is held.
    always_comb begin
        state_next  = state_reg;
        req_ready   = '0;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        frame_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && presetn && arb_valid) begin
                    req_ready  = arb_grant;
                    accept     = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: state_next = WAIT_ACT;
            WAIT_ACT: begin
                if (tx_active) begin
                    state_next = WAIT_DONE;
                end else if (timeout_cnt_reg == TO_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_active) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            last_grant_reg  <= ID_W'(NUM_REQ - 1);
            grant_id_reg    <= '0;
            tx_data_reg     <= '0;
            tx_start_reg    <= 1'b0;
            err_timeout_reg <= 1'b0;
            tx_count_reg    <= '0;
            timeout_cnt_reg <= '0;
        end else begin
            tx_start_reg    <= accept;
            err_timeout_reg <= timeout_hit;
            if (accept) begin
                tx_data_reg     <= req_bytes[arb_idx];
                grant_id_reg    <= arb_idx;
                last_grant_reg  <= arb_idx;
                timeout_cnt_reg <= '0;
            end else if (state_reg == WAIT_ACT) begin
                timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
            end
            if (frame_done) begin
                tx_count_reg <= tx_count_reg + 1'b1;
            end
        end
    end

    assign tx_start    = tx_start_reg;
    assign tx_data     = tx_data_reg;
    assign grant_id    = grant_id_reg;
    assign busy        = (state_reg != IDLE);
    assign err_timeout = err_timeout_reg;
    assign tx_count    = tx_count_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized frames against a queue-free reference of the round-robin
// grant order, captured bytes, frame counter and busy-timeout behaviour.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int BUSY_TIMEOUT = 16;

    logic                   pclk      = 1'b0;
    logic                   presetn   = 1'b1;
    logic                   enable    = 1'b0;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ*8-1:0]   req_data  = '0;
    logic                   tx_active = 1'b0;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   tx_start;
    logic [7:0]             tx_data;
    logic [1:0]             grant_id;
    logic                   busy;
    logic                   err_timeout;
    logic [15:0]            tx_count;

    int vectors     = 0;
    int miscompares = 0;

    int                 last_m  = NUM_REQ - 1;
    logic [15:0]        count_m = '0;
    logic [NUM_REQ-1:0] pending = '0;
    logic [7:0]         data_m [NUM_REQ];

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_active   (tx_active),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout),
        .tx_count    (tx_count)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first pending requester after the previous winner.
    function automatic int pick(input logic [NUM_REQ-1:0] p, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (last + k) % NUM_REQ;
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive();
        req_valid = pending;
        for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = data_m[i];
    endtask

    // New requesters appear at random; pending ones keep their byte until accepted.
    task automatic refill();
        logic [NUM_REQ-1:0] fresh;
        int r;
        fresh = NUM_REQ'($urandom);
        if ((pending | fresh) == '0) begin
            r = int'($urandom_range(0, NUM_REQ - 1));
            fresh[r] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fresh[i] && !pending[i]) begin
                pending[i] = 1'b1;
                data_m[i]  = 8'($urandom);
            end
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({pfx, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({pfx, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({pfx, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_err_timeout"}, 32'(err_timeout), 32'd0);
        chk({pfx, "_tx_count"}, 32'(tx_count), 32'd0);
    endtask

    // Entered at a point in IDLE before the rising edge; leaves in IDLE at a falling edge.
    task automatic run_frame(input int d, input int len, input bit hang, input bit drop_en);
        int w;
        drive();
        w = pick(pending, last_m);
        #1;
        chk("req_ready", 32'(req_ready), 32'(1) << w);
        @(negedge pclk);
        chk("tx_start", 32'(tx_start), 32'd1);
        chk("tx_data", 32'(tx_data), 32'(data_m[w]));
        chk("grant_id", 32'(grant_id), 32'(w));
        chk("busy_launch", 32'(busy), 32'd1);
        chk("err_idle", 32'(err_timeout), 32'd0);
        last_m     = w;
        pending[w] = 1'b0;
        drive();
        #1;
        chk("ready_busy", 32'(req_ready), 32'd0);
        @(negedge pclk);
        chk("tx_start_pulse", 32'(tx_start), 32'd0);
        if (hang) begin
            repeat (BUSY_TIMEOUT - 1) begin
                @(negedge pclk);
                chk("err_early", 32'(err_timeout), 32'd0);
            end
            @(negedge pclk);
            chk("err_timeout", 32'(err_timeout), 32'd1);
            chk("busy_timeout", 32'(busy), 32'd0);
            chk("count_timeout", 32'(tx_count), 32'(count_m));
            $display("frame req %0d byte %02h timeout count %04h", w, data_m[w], count_m);
        end else begin
            repeat (d) @(negedge pclk);
            tx_active = 1'b1;
            if (drop_en) enable = 1'b0;
            repeat (len) @(negedge pclk);
            chk("busy_active", 32'(busy), 32'd1);
            tx_active = 1'b0;
            @(negedge pclk);
            count_m = count_m + 16'd1;
            chk("busy_done", 32'(busy), 32'd0);
            chk("tx_count", 32'(tx_count), 32'(count_m));
            chk("err_done", 32'(err_timeout), 32'd0);
            $display("frame req %0d byte %02h done count %04h", w, data_m[w], count_m);
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) data_m[i] = 8'h10 + 8'(i);
        enable  = 1'b1;
        pending = '1;
        drive();
        #2 presetn = 1'b0;
        repeat (2) @(negedge pclk);
        chk_reset("reset");

        // All four requesters valid: order 0,1,2,3,0 with bytes 10..13,10
        presetn = 1'b1;
        for (int f = 0; f < 5; f++) begin
            pending = '1;
            run_frame(1, 3, 1'b0, 1'b0);
        end

        // Single request on requester 2
        pending   = 4'b0100;
        data_m[2] = 8'hA5;
        run_frame(0, 2, 1'b0, 1'b0);

        for (int f = 0; f < 30; f++) begin
            refill();
            run_frame(int'($urandom_range(0, 5)), int'($urandom_range(1, 8)), 1'b0, 1'b0);
        end

        // Core never answers, then the next requester in rotation is served
        pending = '1;
        run_frame(0, 0, 1'b1, 1'b0);
        run_frame(2, 2, 1'b0, 1'b0);

        enable = 1'b0;
        refill();
        drive();
        repeat (4) begin
            @(negedge pclk);
            chk("ready_disabled", 32'(req_ready), 32'd0);
            chk("busy_disabled", 32'(busy), 32'd0);
        end
        enable = 1'b1;

        // enable dropped while the core is sending
        run_frame(1, 4, 1'b0, 1'b1);
        refill();
        drive();
        #1;
        chk("ready_after_drop", 32'(req_ready), 32'd0);
        enable = 1'b1;

        // Counter wrap
        force dut.tx_count_reg = 16'hFFFE;
        #1;
        release dut.tx_count_reg;
        count_m = 16'hFFFE;
        refill();
        run_frame(0, 1, 1'b0, 1'b0);
        refill();
        run_frame(0, 1, 1'b0, 1'b0);

        // Reset while the frame is in WAIT_DONE
        pending = '1;
        drive();
        @(negedge pclk);
        @(negedge pclk);
        tx_active = 1'b1;
        @(negedge pclk);
        chk("busy_before_reset", 32'(busy), 32'd1);
        presetn   = 1'b0;
        tx_active = 1'b0;
        #1;
        chk_reset("midreset");
        @(negedge pclk);
        chk_reset("midreset_hold");
        presetn = 1'b1;
        last_m  = NUM_REQ - 1;
        count_m = '0;
        run_frame(1, 2, 1'b0, 1'b0);
        chk("grant_after_reset", 32'(grant_id), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
